// File: rtl/req_index_encoder_pkg.sv
// req_index_encoder_pkg: shared state encoding and counter width for req_index_encoder
package req_index_encoder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1} state_t;
    localparam int OVF_CNT_W = 8;
endpackage

// File: rtl/req_index_encoder_rr_pick.sv
// rr_pick: combinational round-robin finder, first set bit of vec at or above ptr, wrapping to 0
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_off;
    logic [IW:0]    w_sum;
    // rotating the doubled vector puts the search start at bit 0
    assign w_dbl = {vec, vec} >> ptr;
    assign w_rot = w_dbl[N-1:0];
    always_comb begin
        w_off = '0;
        found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (IW+1)'(j);
                found = 1'b1;
            end
        end
    end
    assign w_sum = {1'b0, ptr} + w_off;
    assign idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
endmodule

// File: rtl/req_index_encoder.sv
// req_index_encoder: captures request pulses and emits their indices round-robin over valid/ready;
// defining REQ_INDEX_ENCODER_OVF_CNT_EN adds the saturating overflow counter o_ovf_cnt.
module req_index_encoder
    import req_index_encoder_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_index,
    input  logic          i_ready,
    output logic [N-1:0]  o_pending,
    output logic          o_overflow
`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0] o_ovf_cnt
`endif
);
    function automatic logic [N-1:0] onehot_of(input logic [IW-1:0] idx);
        onehot_of      = '0;
        onehot_of[idx] = 1'b1;
    endfunction

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic          w_accept;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_masked;
    logic          w_found;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_ptr_inc;

    assign w_accept  = o_valid && i_ready;
    assign w_clr     = w_accept ? onehot_of(o_index) : '0;
    assign w_masked  = o_pending & ~w_clr;
    assign w_ptr_inc = (o_index == IW'(N - 1)) ? '0 : o_index + 1'b1;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .vec   (w_masked),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            o_valid    <= 1'b0;
            o_index    <= '0;
            o_pending  <= '0;
            o_overflow <= 1'b0;
        end else begin
            // a request landing on its own accept re-arms the bit without overflow
            o_pending  <= w_masked | i_req;
            o_overflow <= |(i_req & w_masked);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= PRESENT;
                        o_index <= w_idx;
                        o_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_accept) begin
                        r_ptr <= w_ptr_inc;
                        if (w_found) begin
                            o_index <= w_idx;
                        end else begin
                            r_state <= IDLE;
                            o_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ovf_cnt <= '0;
        end else if (o_overflow && o_ovf_cnt != '1) begin
            o_ovf_cnt <= o_ovf_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_req_index_encoder.sv
// tb_req_index_encoder: randomized and directed scoreboard bench against a behavioural pending-set model
module tb_req_index_encoder;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  i_req = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [IW-1:0] o_index;
    logic [N-1:0]  o_pending;
    logic          o_overflow;
`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
    logic [7:0]    o_ovf_cnt;
`endif

    req_index_encoder #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .o_valid    (o_valid),
        .o_index    (o_index),
        .i_ready    (i_ready),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
        ,
        .o_ovf_cnt  (o_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // behavioural model: set of pending lines, search pointer, presented index
    bit m_pend[N];
    int m_ptr   = 0;
    int m_idx   = 0;
    bit m_valid = 0;
    bit m_ovf   = 0;
    int m_cnt   = 0;
    int exp_q[$];
    int got_q[$];
    int checks = 0;
    int passes = 0;

    function automatic int pend_vec();
        int v = 0;
        for (int k = 0; k < N; k++) if (m_pend[k]) v += (1 << k);
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) m_pend[k] = 0;
        m_ptr = 0; m_idx = 0; m_valid = 0; m_ovf = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    // drive one cycle of inputs (called at posedge+1) and advance the model across the edge
    task automatic step(input logic [N-1:0] req, input bit rdy);
        bit acc;
        bit avail[N];
        bit n_pend[N];
        int pick, n_ptr, n_idx, n_cnt;
        bit n_valid, n_ovf;
        i_req = req;
        i_ready = rdy;
        acc = m_valid && rdy;
        if (acc) exp_q.push_back(m_idx);
        for (int k = 0; k < N; k++) avail[k] = m_pend[k] && !(acc && k == m_idx);
        pick = -1;
        for (int o = 0; o < N; o++) if (pick < 0 && avail[(m_ptr + o) % N]) pick = (m_ptr + o) % N;
        n_ovf = 0;
        for (int k = 0; k < N; k++) if (req[k] && avail[k]) n_ovf = 1;
        n_cnt = (m_ovf && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        n_ptr = m_ptr; n_idx = m_idx; n_valid = m_valid;
        if (!m_valid) begin
            if (pick >= 0) begin n_valid = 1; n_idx = pick; end
        end else if (acc) begin
            n_ptr = (m_idx + 1) % N;
            if (pick >= 0) n_idx = pick;
            else n_valid = 0;
        end
        for (int k = 0; k < N; k++) n_pend[k] = avail[k] || req[k];
        @(posedge clk);
        #1;
        m_pend = n_pend; m_ptr = n_ptr; m_idx = n_idx; m_valid = n_valid; m_ovf = n_ovf; m_cnt = n_cnt;
    endtask

    task automatic steps(input int n, input logic [N-1:0] req, input bit rdy);
        for (int i = 0; i < n; i++) step(req, rdy);
    endtask

    task automatic do_reset();
        i_req = '0;
        i_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_pending", o_pending, 0);
        check("async_rst_overflow", o_overflow, 0);
        check("async_rst_index", o_index, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_order(input string nm, input int n, input int a, input int b, input int c);
        int e[3];
        e[0] = a; e[1] = b; e[2] = c;
        check({nm, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check(nm, got_q[i], e[i]);
        got_q.delete();
    endtask

    // monitor: compares registered outputs with the model and pops the scoreboard on each accept
    initial begin
        forever begin
            @(negedge clk);
            check("valid", o_valid, m_valid);
            check("pending", o_pending, pend_vec());
            check("overflow", o_overflow, m_ovf);
`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
            check("ovf_cnt", o_ovf_cnt, m_cnt);
`endif
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                got_q.push_back(o_index);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL index: accept of %0d with no expected index queued", o_index);
                end else begin
                    check("index", o_index, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_pending", o_pending, 0);
        check("rst_index", o_index, 0);
        rst_n = 1'b1;
        steps(5, 8'h00, 1'b1);
        expect_order("idle_order", 0, 0, 0, 0);
        // two requests, consumer always ready
        step(8'b0010_0100, 1'b1);
        check("latency_valid_low", o_valid, 0);
        step(8'h00, 1'b1);
        check("latency_valid_high", o_valid, 1);
        steps(4, 8'h00, 1'b1);
        expect_order("order_25", 2, 2, 5, 0);
        check("drained_pending", o_pending, 0);
        // consumer stalls while index 2 is presented
        step(8'b0010_0100, 1'b0);
        steps(4, 8'h00, 1'b0);
        check("stall_index", o_index, 2);
        check("stall_pending", o_pending, 8'h24);
        steps(4, 8'h00, 1'b1);
        expect_order("stall_order", 2, 2, 5, 0);
        // pointer now 6: wrap-around order
        step(8'b1000_0011, 1'b1);
        steps(5, 8'h00, 1'b1);
        expect_order("wrap_order", 3, 7, 0, 1);
        // overflow on a presented, unaccepted line
        step(8'h08, 1'b0);
        step(8'h00, 1'b0);
        check("ovf_present_index", o_index, 3);
        step(8'h08, 1'b0);
        check("ovf_pulse", o_overflow, 1);
        step(8'h00, 1'b0);
        check("ovf_one_cycle", o_overflow, 0);
        step(8'h08, 1'b1);
        check("ovf_set_on_accept", o_overflow, 0);
        steps(4, 8'h00, 1'b1);
        expect_order("represent_order", 2, 3, 3, 0);
        // reset while presenting with three pending lines
        step(8'h07, 1'b0);
        steps(2, 8'h00, 1'b0);
        check("pre_rst_pending", o_pending, 8'h07);
        do_reset();
        steps(3, 8'h00, 1'b1);
        got_q.delete();
        // sustained overflow on one presented line
        step(8'h10, 1'b0);
        step(8'h00, 1'b0);
        steps(300, 8'h10, 1'b0);
`ifdef REQ_INDEX_ENCODER_OVF_CNT_EN
        step(8'h00, 1'b0);
        check("ovf_cnt_saturate", o_ovf_cnt, 255);
`endif
        steps(4, 8'h00, 1'b1);
        // randomized traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            step(r, $urandom_range(0, 3) != 0);
            if (i == 1500) do_reset();
        end
        steps(2 * N + 4, 8'h00, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_valid", o_valid, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
